// File: rtl/shift_add_mul8.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around one 8-bit ripple-carry adder.
// Optional multiply-accumulate mode enabled by defining SHIFT_ADD_MUL_ACC_EN.
module shift_add_mul8 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
`ifdef SHIFT_ADD_MUL_ACC_EN
    input  logic               acc_clr,
`endif
    output logic               busy
);

    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    if (WIDTH != 8) begin : g_bad_width
        $error("shift_add_mul8: the adder datapath is 8 bits, WIDTH must be 8");
    end

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        DONE
`ifdef SHIFT_ADD_MUL_ACC_EN
        , ACC_LO
        , ACC_HI
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;

`ifdef SHIFT_ADD_MUL_ACC_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_op;
    logic               acc_c;
    logic               clr_q;

    assign acc_op = clr_q ? '0 : acc;
`endif

    // Shared adder: every arithmetic step of the block goes through these operands.
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        add_x   = hi;
        add_y   = lo[0] ? mcand : '0;
        add_cin = 1'b0;
`ifdef SHIFT_ADD_MUL_ACC_EN
        case (state)
            ACC_LO: begin
                add_x = lo;
                add_y = acc_op[WIDTH-1:0];
            end
            ACC_HI: begin
                add_x   = hi;
                add_y   = acc_op[2*WIDTH-1:WIDTH];
                add_cin = acc_c;
            end
            default: ;
        endcase
`endif
    end

    always_comb begin
        logic [WIDTH:0] carry;
        carry    = '0;
        add_s    = '0;
        carry[0] = add_cin;
        for (int i = 0; i < WIDTH; i++) begin
            add_s[i]     = add_x[i] ^ add_y[i] ^ carry[i];
            carry[i + 1] = (add_x[i] & add_y[i]) | (carry[i] & (add_x[i] ^ add_y[i]));
        end
        add_cout = carry[WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            prod      <= '0;
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            cnt       <= '0;
`ifdef SHIFT_ADD_MUL_ACC_EN
            acc       <= '0;
            acc_c     <= 1'b0;
            clr_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= a;
                        lo       <= b;
                        hi       <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
`ifdef SHIFT_ADD_MUL_ACC_EN
                        clr_q    <= acc_clr;
`endif
                    end
                end
                CALC: begin
                    // Adder carry becomes the new MSB of the 17-bit right shift.
                    {hi, lo} <= {add_cout, add_s, lo[WIDTH-1:1]};
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) begin
`ifdef SHIFT_ADD_MUL_ACC_EN
                        state     <= ACC_LO;
`else
                        state     <= DONE;
                        out_valid <= 1'b1;
                        prod      <= {add_cout, add_s, lo[WIDTH-1:1]};
`endif
                    end
                end
`ifdef SHIFT_ADD_MUL_ACC_EN
                ACC_LO: begin
                    lo    <= add_s;
                    acc_c <= add_cout;
                    state <= ACC_HI;
                end
                ACC_HI: begin
                    hi        <= add_s;
                    acc       <= {add_s, lo};
                    prod      <= {add_s, lo};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
